// File: rtl/uart_rx_param_if.sv
// Output stream of the parametrised UART receiver: received word, its error
// flags and the valid/ready handshake towards the consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, none/odd/even parity, 1/2 stop
// bits, oversampled line with 3-sample majority vote per bit, start-glitch
// rejection, parity/framing/overrun reporting and a valid/ready output.
module uart_rx_param #(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           rx,
  uart_rx_param_if.master out_if,
  output logic           overrun,
  output logic           busy
);

  localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-out-of-three vote over the mid-bit samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // x is the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(input logic x);
    if (PARITY == 1) return ~x;
    else if (PARITY == 2) return x;
    else return 1'b0;
  endfunction

  logic                 rx_meta;
  logic                 rx_s;
  logic [TICK_W-1:0]    tick_cnt;
  logic [SAMP_W-1:0]    samp_idx;
  logic [2:0]           smp;
  logic                 tick;
  logic                 bit_end;
  logic                 vote;
  logic                 start_det;
  state_t               state;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 ferr_acc;
  logic                 commit;

  assign tick      = (tick_cnt == TICK_LAST);
  assign bit_end   = tick && (samp_idx == SAMP_LAST);
  assign vote      = maj3(smp);
  assign start_det = (state == S_IDLE) && !rx_s;
  assign busy      = (state != S_IDLE);

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running tick divider and per-bit sample index, realigned on a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      samp_idx <= '0;
    end else if (start_det) begin
      tick_cnt <= '0;
      samp_idx <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_idx <= (samp_idx == SAMP_LAST) ? '0 : samp_idx + SAMP_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Capture the three samples around the bit centre for the vote at bit end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp <= 3'b111;
    end else if (tick) begin
      if (samp_idx == SAMP_A) smp[0] <= rx_s;
      if (samp_idx == SAMP_B) smp[1] <= rx_s;
      if (samp_idx == SAMP_C) smp[2] <= rx_s;
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state == S_DATA && bit_end) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  // Frame sequencer; commit is raised for the cycle after the last stop-bit vote.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      ferr_acc <= 1'b0;
      commit   <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            if (vote) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              par_acc  <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (bit_end) begin
            par_acc <= par_acc ^ vote;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            par_acc <= par_acc ^ vote;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            ferr_acc <= ferr_acc | ~vote;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              commit  <= 1'b1;
              state   <= (ferr_acc || !vote) ? S_BREAK : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output holding register: load on commit when free or being drained, else flag overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_if.data_out   <= '0;
      out_if.data_valid <= 1'b0;
      out_if.parity_err <= 1'b0;
      out_if.frame_err  <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!out_if.data_valid || out_if.data_ready) begin
          out_if.data_out   <= shreg;
          out_if.data_valid <= 1'b1;
          out_if.parity_err <= parity_error(par_acc);
          out_if.frame_err  <= ferr_acc;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_if.data_valid && out_if.data_ready) begin
        out_if.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one default-rate instance plus three fast-rate
// instances (8N1, 8E1, 9O2) driven with directed and random frames.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] rx_v;
  logic       ovr0, ovr1, ovr2, ovr3;
  logic       busy0, busy1, busy2, busy3;
  int         checks = 0;
  int         errors = 0;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();
  uart_rx_param_if #(.DATA_BITS(9)) if3 ();

  uart_rx_param u0 (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[0]), .out_if(if0.master),
    .overrun(ovr0), .busy(busy0)
  );
  uart_rx_param #(
    .CLOCK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[1]), .out_if(if1.master),
    .overrun(ovr1), .busy(busy1)
  );
  uart_rx_param #(
    .CLOCK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[2]), .out_if(if2.master),
    .overrun(ovr2), .busy(busy2)
  );
  uart_rx_param #(
    .CLOCK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[3]), .out_if(if3.master),
    .overrun(ovr3), .busy(busy3)
  );

  // Frame format of each instance.
  function automatic int bitclk(input int idx); return (idx == 0) ? 1248 : 64; endfunction
  function automatic int dbits(input int idx);  return (idx == 3) ? 9 : 8;     endfunction
  function automatic int par(input int idx);    return (idx == 2) ? 2 : (idx == 3) ? 1 : 0; endfunction
  function automatic int stops(input int idx);  return (idx == 3) ? 2 : 1;     endfunction

  function automatic logic get_valid(input int idx);
    case (idx)
      0: return if0.data_valid;
      1: return if1.data_valid;
      2: return if2.data_valid;
      default: return if3.data_valid;
    endcase
  endfunction

  function automatic logic [8:0] get_data(input int idx);
    case (idx)
      0: return {1'b0, if0.data_out};
      1: return {1'b0, if1.data_out};
      2: return {1'b0, if2.data_out};
      default: return if3.data_out;
    endcase
  endfunction

  function automatic logic get_pe(input int idx);
    case (idx)
      0: return if0.parity_err;
      1: return if1.parity_err;
      2: return if2.parity_err;
      default: return if3.parity_err;
    endcase
  endfunction

  function automatic logic get_fe(input int idx);
    case (idx)
      0: return if0.frame_err;
      1: return if1.frame_err;
      2: return if2.frame_err;
      default: return if3.frame_err;
    endcase
  endfunction

  // Parity bit a correct transmitter would send for data d.
  function automatic logic good_par(input int idx, input logic [8:0] d);
    logic x;
    x = 1'b0;
    for (int i = 0; i < dbits(idx); i++) x = x ^ d[i];
    return (par(idx) == 1) ? ~x : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int idx, input logic v, input int nbits);
    rx_v[idx] = v;
    repeat (nbits * bitclk(idx)) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stopv);
    hold(idx, 1'b0, 1);
    for (int i = 0; i < dbits(idx); i++) hold(idx, d[i], 1);
    if (par(idx) != 0) hold(idx, pbit, 1);
    for (int i = 0; i < stops(idx); i++) hold(idx, stopv[i], 1);
  endtask

  task automatic wait_valid(input int idx, input int bound, output logic got,
                            output logic [8:0] d, output logic pe, output logic fe);
    got = 1'b0; d = '0; pe = 1'b0; fe = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (get_valid(idx)) begin
        got = 1'b1;
        d   = get_data(idx);
        pe  = get_pe(idx);
        fe  = get_fe(idx);
      end
    end
  endtask

  // Send one frame with data_ready high and compare against the frame rules.
  task automatic frame_check(input int idx, input logic [8:0] d, input logic pbit,
                             input logic [1:0] stopv, input string tag);
    logic       got, pe, fe, exp_pe, exp_fe;
    logic [8:0] dat, mask;
    mask   = 9'((1 << dbits(idx)) - 1);
    exp_pe = (par(idx) != 0) && (pbit !== good_par(idx, d));
    exp_fe = (stopv[0] == 1'b0) || ((stops(idx) == 2) && (stopv[1] == 1'b0));
    send_frame(idx, d, pbit, stopv);
    wait_valid(idx, 3 * bitclk(idx), got, dat, pe, fe);
    chk({tag, "_valid"}, 32'(got), 32'd1);
    chk({tag, "_data"}, 32'(dat), 32'(d & mask));
    chk({tag, "_perr"}, 32'(pe), 32'(exp_pe));
    chk({tag, "_ferr"}, 32'(fe), 32'(exp_fe));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(get_valid(idx)), 32'd0);
    hold(idx, 1'b1, 2);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       got, pe, fe;
    logic [8:0] dat, rd;
    int         cnt, bad;
    logic       pb;
    logic [1:0] sv;

    reset_n = 1'b0;
    rx_v    = 4'hF;
    if0.data_ready = 1'b1;
    if1.data_ready = 1'b1;
    if2.data_ready = 1'b1;
    if3.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(if0.data_valid), 32'd0);
    chk("rst_data",  32'(if0.data_out),   32'd0);
    chk("rst_perr",  32'(if0.parity_err), 32'd0);
    chk("rst_ferr",  32'(if0.frame_err),  32'd0);
    chk("rst_ovr",   32'(ovr0),           32'd0);
    chk("rst_busy",  32'({busy3, busy2, busy1, busy0}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default rate: clean 0xA5
    frame_check(0, 9'h0A5, 1'b0, 2'b11, "def_a5");

    // Default rate: 400-cycle low glitch must be rejected
    hold(0, 1'b1, 1);
    rx_v[0] = 1'b0;
    repeat (400) @(negedge clk);
    chk("glitch_busy", 32'(busy0), 32'd1);
    rx_v[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1250; i++) begin
      @(negedge clk);
      if (if0.data_valid) cnt++;
    end
    chk("glitch_novalid", 32'(cnt), 32'd0);
    chk("glitch_idle", 32'(busy0), 32'd0);

    // Even parity: 0x3C with wrong and right parity bits
    hold(2, 1'b1, 1);
    frame_check(2, 9'h03C, 1'b1, 2'b11, "par_bad");
    frame_check(2, 9'h03C, 1'b0, 2'b11, "par_ok");

    // Framing error with the line held low, then recovery
    hold(1, 1'b1, 1);
    send_frame(1, 9'h055, 1'b0, 2'b00);
    wait_valid(1, 2 * bitclk(1), got, dat, pe, fe);
    chk("fe_valid", 32'(got), 32'd1);
    chk("fe_data",  32'(dat), 32'h55);
    chk("fe_ferr",  32'(fe),  32'd1);
    cnt = 0;
    for (int i = 0; i < 2 * bitclk(1); i++) begin
      @(negedge clk);
      if (if1.data_valid) cnt++;
    end
    chk("fe_break_busy", 32'(busy1), 32'd1);
    chk("fe_break_quiet", 32'(cnt), 32'd0);
    hold(1, 1'b1, 2);
    chk("fe_recovered", 32'(busy1), 32'd0);
    frame_check(1, 9'h012, 1'b0, 2'b11, "after_break");

    // Overrun: consumer stalled across two frames
    if1.data_ready = 1'b0;
    send_frame(1, 9'h011, 1'b0, 2'b11);
    wait_valid(1, 2 * bitclk(1), got, dat, pe, fe);
    chk("ovr_first_valid", 32'(got), 32'd1);
    chk("ovr_first_data",  32'(dat), 32'h11);
    hold(1, 1'b1, 1);
    send_frame(1, 9'h022, 1'b0, 2'b11);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 2 * bitclk(1); i++) begin
      @(negedge clk);
      if (ovr1) cnt++;
      if (if1.data_out !== 8'h11 || !if1.data_valid) bad++;
    end
    chk("ovr_pulses", 32'(cnt), 32'd1);
    chk("ovr_held_stable", 32'(bad), 32'd0);
    chk("ovr_held_data", 32'(if1.data_out), 32'h11);
    if1.data_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accepted", 32'(if1.data_valid), 32'd0);

    // Reset in the middle of the data bits of 0xFF
    hold(1, 1'b1, 1);
    hold(1, 1'b0, 1);
    hold(1, 1'b1, 4);
    chk("mid_busy", 32'(busy1), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy1),           32'd0);
    chk("mid_rst_valid", 32'(if1.data_valid),  32'd0);
    chk("mid_rst_data",  32'(if1.data_out),    32'd0);
    chk("mid_rst_ovr",   32'(ovr1),            32'd0);
    rx_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold(1, 1'b1, 2);
    frame_check(1, 9'h00F, 1'b0, 2'b11, "post_rst");

    // Random frames on each fast format
    for (int n = 0; n < 12; n++) begin
      rd = 9'($urandom);
      pb = good_par(3, rd) ^ ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      frame_check(3, rd, pb, sv, "rnd_9o2");
    end
    for (int n = 0; n < 10; n++) begin
      rd = 9'($urandom_range(0, 255));
      pb = good_par(2, rd) ^ ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b11;
      frame_check(2, rd, pb, sv, "rnd_8e1");
    end
    for (int n = 0; n < 6; n++) begin
      rd = 9'($urandom_range(0, 255));
      frame_check(1, rd, 1'b0, 2'b11, "rnd_8n1");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
